// File: rtl/tune_cmd_decoder.sv
// Parses 11-byte tuning frames (A5, CMD, D7..D0, CSUM) from the UART receiver,
// loads the NCO phase increments and answers each complete frame with ACK/NAK.
module tune_cmd_decoder #(
  parameter int unsigned TIMEOUT_CLKS = 133000,
  parameter logic [63:0] CARR_RESET   = 64'h01ED3E9CFE280000,
  parameter logic [63:0] GEN_RESET    = 64'h01ECC07802400000
) (
  input  logic        osc_clk,
  input  logic        rst,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Tx_Active,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  output logic [63:0] phase_inc_carr,
  output logic [63:0] phase_inc_carrGen,
  output logic [1:0]  o_load,
  output logic        o_frame_err,
  output logic [2:0]  dbg_state
);

  // Handshake: i_Rx_DV and o_Tx_DV are single-cycle strobes with no back-pressure;
  // the response strobe is held off while i_Tx_Active is high, and bytes seen
  // while a response is pending are discarded.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [63:0]   shadow, shadow_n;
  logic [7:0]    csum, csum_n;
  logic [7:0]    cmd, cmd_n;
  logic [7:0]    resp, resp_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [63:0]   carr_n, gen_n;
  logic [1:0]    load_n;
  logic          err_n, tx_dv_n;
  logic [7:0]    tx_byte_n;
  logic          in_frame, timeout;

  assign dbg_state = state;
  assign in_frame  = (state == S_CMD) || (state == S_DATA) || (state == S_CSUM);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout   = in_frame && !i_Rx_DV && (tcnt == TW'(TIMEOUT_CLKS - 1));

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    shadow_n  = shadow;
    csum_n    = csum;
    cmd_n     = cmd;
    resp_n    = resp;
    tcnt_n    = (i_Rx_DV || !in_frame) ? '0 : tcnt + 1'b1;
    carr_n    = phase_inc_carr;
    gen_n     = phase_inc_carrGen;
    load_n    = 2'b00;
    err_n     = 1'b0;
    tx_dv_n   = 1'b0;
    tx_byte_n = o_Tx_Byte;

    case (state)
      S_IDLE: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC) begin
          state_n  = S_CMD;
          shadow_n = '0;
          csum_n   = '0;
        end
      end
      S_CMD: begin
        if (i_Rx_DV) begin
          cmd_n   = i_Rx_Byte;
          csum_n  = i_Rx_Byte;
          idx_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (i_Rx_DV) begin
          shadow_n = {shadow[55:0], i_Rx_Byte};
          csum_n   = csum ^ i_Rx_Byte;
          idx_n    = idx + 3'd1;
          if (idx == 3'd7) state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        if (i_Rx_DV) begin
          state_n = S_RESP;
          if (i_Rx_Byte == csum && cmd == 8'h01) begin
            carr_n = shadow;
            load_n = 2'b01;
            resp_n = ACK;
          end else if (i_Rx_Byte == csum && cmd == 8'h02) begin
            gen_n  = shadow;
            load_n = 2'b10;
            resp_n = ACK;
          end else begin
            err_n  = 1'b1;
            resp_n = NAK;
          end
        end
      end
      S_RESP: begin
        if (!i_Tx_Active) begin
          tx_dv_n   = 1'b1;
          tx_byte_n = resp;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (timeout) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (rst) begin
      state             <= S_IDLE;
      idx               <= '0;
      shadow            <= '0;
      csum              <= '0;
      cmd               <= '0;
      resp              <= '0;
      tcnt              <= '0;
      phase_inc_carr    <= CARR_RESET;
      phase_inc_carrGen <= GEN_RESET;
      o_load            <= 2'b00;
      o_frame_err       <= 1'b0;
      o_Tx_DV           <= 1'b0;
      o_Tx_Byte         <= 8'h00;
    end else begin
      state             <= state_n;
      idx               <= idx_n;
      shadow            <= shadow_n;
      csum              <= csum_n;
      cmd               <= cmd_n;
      resp              <= resp_n;
      tcnt              <= tcnt_n;
      phase_inc_carr    <= carr_n;
      phase_inc_carrGen <= gen_n;
      o_load            <= load_n;
      o_frame_err       <= err_n;
      o_Tx_DV           <= tx_dv_n;
      o_Tx_Byte         <= tx_byte_n;
    end
  end

endmodule

// File: tb/tb_tune_cmd_decoder.sv
// Directed bench for tune_cmd_decoder: hand-built frames, response scoreboard,
// and checks on load/error pulses, timeout, busy transmitter and reset.
module tb_tune_cmd_decoder;

  localparam int unsigned TOUT = 50;
  localparam logic [63:0] CARR_RST = 64'h01ED3E9CFE280000;
  localparam logic [63:0] GEN_RST  = 64'h01ECC07802400000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_active = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] carr, gen;
  logic [1:0]  load;
  logic        frame_err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_seen  = 0;
  int err_seen = 0;
  logic tx_prev = 1'b0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  tune_cmd_decoder #(
    .TIMEOUT_CLKS(TOUT),
    .CARR_RESET  (CARR_RST),
    .GEN_RESET   (GEN_RST)
  ) dut (
    .osc_clk          (clk),
    .rst              (rst),
    .i_Rx_DV          (rx_dv),
    .i_Rx_Byte        (rx_byte),
    .i_Tx_Active      (tx_active),
    .o_Tx_DV          (tx_dv),
    .o_Tx_Byte        (tx_byte),
    .phase_inc_carr   (carr),
    .phase_inc_carrGen(gen),
    .o_load           (load),
    .o_frame_err      (frame_err),
    .dbg_state        (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every response strobe must match the next expected byte
  always @(negedge clk) begin
    if (frame_err) err_seen++;
    if (tx_dv) begin
      tx_seen++;
      check("tx_back2back", {63'd0, tx_prev}, 64'd0);
      if (exp_q.size() == 0) check("tx_unexpected", {63'd0, tx_dv}, 64'd0);
      else check("tx_byte", {56'd0, tx_byte}, {56'd0, exp_q.pop_front()});
    end
    tx_prev = tx_dv;
  end

  // drivers
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [63:0] data, input logic [7:0] csum_flip);
    logic [7:0] cs;
    cs = cmd;
    send_byte(8'hA5);
    send_byte(cmd);
    for (int i = 7; i >= 0; i--) begin
      send_byte(data[i*8 +: 8]);
      cs = cs ^ data[i*8 +: 8];
    end
    send_byte(cs ^ csum_flip);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 50 && tx_seen < n; i++) @(posedge clk);
    #1;
    check("tx_count", tx_seen, n);
  endtask

  int err0, tx0;

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_carr", carr, CARR_RST);
    check("rst_gen", gen, GEN_RST);
    check("rst_tx_dv", {63'd0, tx_dv}, 64'd0);
    check("rst_tx_byte", {56'd0, tx_byte}, 64'd0);
    check("rst_load", {62'd0, load}, 64'd0);
    check("rst_err", {63'd0, frame_err}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    rst = 1'b0;

    // valid carrier write, csum = 01^12^34^56^78 = 09
    exp_q.push_back(8'h06);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h09);
    check("carr_val", carr, 64'h0000000012345678);
    check("carr_load", {62'd0, load}, 64'd1);
    check("carr_gen_same", gen, GEN_RST);
    check("carr_state_resp", {61'd0, dbg_state}, 64'd4);
    @(posedge clk); #1;
    check("carr_load_pulse", {62'd0, load}, 64'd0);
    wait_tx(1);

    // bad checksum on gen frame
    exp_q.push_back(8'h15);
    send_frame(8'h02, 64'h1122334455667788, 8'h01);
    check("badcs_err", {63'd0, frame_err}, 64'd1);
    check("badcs_load", {62'd0, load}, 64'd0);
    check("badcs_gen", gen, GEN_RST);
    wait_tx(2);

    // valid gen write
    exp_q.push_back(8'h06);
    send_frame(8'h02, 64'h0123456789ABCDEF, 8'h00);
    check("gen_val", gen, 64'h0123456789ABCDEF);
    check("gen_load", {62'd0, load}, 64'd2);
    check("gen_err", {63'd0, frame_err}, 64'd0);
    wait_tx(3);

    // noise then unknown command with correct checksum
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("noise_idle", {61'd0, dbg_state}, 64'd0);
    exp_q.push_back(8'h15);
    send_frame(8'h07, 64'hCAFEF00D12345678, 8'h00);
    check("unk_err", {63'd0, frame_err}, 64'd1);
    check("unk_load", {62'd0, load}, 64'd0);
    check("unk_carr", carr, 64'h0000000012345678);
    check("unk_gen", gen, 64'h0123456789ABCDEF);
    wait_tx(4);

    // timeout after partial frame
    err0 = err_seen;
    tx0 = tx_seen;
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    repeat (TOUT + 10) @(posedge clk);
    #1;
    check("tout_err_once", err_seen - err0, 1);
    check("tout_no_tx", tx_seen, tx0);
    check("tout_state", {61'd0, dbg_state}, 64'd0);
    check("tout_carr", carr, 64'h0000000012345678);
    exp_q.push_back(8'h06);
    send_frame(8'h01, 64'h0000000000000055, 8'h00);
    check("tout_next_carr", carr, 64'h0000000000000055);
    wait_tx(5);

    // transmitter busy across the checksum byte
    tx_active = 1'b1;
    exp_q.push_back(8'h06);
    send_frame(8'h01, 64'hDEADBEEF00000001, 8'h00);
    check("busy_carr", carr, 64'hDEADBEEF00000001);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    repeat (14) @(posedge clk);
    #1;
    check("busy_hold", tx_seen, 5);
    check("busy_state", {61'd0, dbg_state}, 64'd4);
    tx_active = 1'b0;
    @(posedge clk); #1;
    check("busy_tx_dv", {63'd0, tx_dv}, 64'd1);
    check("busy_tx_byte", {56'd0, tx_byte}, 64'h06);
    @(posedge clk); #1;
    check("busy_tx_once", {63'd0, tx_dv}, 64'd0);
    check("busy_dropped", {61'd0, dbg_state}, 64'd0);
    check("busy_count", tx_seen, 6);

    // reset in the middle of a frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h77);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_carr", carr, CARR_RST);
    check("mrst_gen", gen, GEN_RST);
    check("mrst_state", {61'd0, dbg_state}, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("mrst_no_tx", tx_seen, 6);
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tune_cmd_decoder.md
# tune_cmd_decoder

Host-side command decoder for the SDR tuning path. It consumes the byte stream from the UART receiver (`o_Rx_DV`/`o_Rx_Byte`) and parses fixed-length tuning frames. It loads the 64-bit phase increments that drive the receive NCO and the generator NCO, and returns a one-byte ACK/NAK to the UART transmitter. This replaces the hardwired phase-increment constants and the rx→tx loopback in the top level.

## Interface
Parameters:
- `TIMEOUT_CLKS`, 133000: inter-byte timeout in `osc_clk` cycles (1 ms at 133 MHz).
- `CARR_RESET`, 64'h01ED3E9CFE280000: reset value of `phase_inc_carr`.
- `GEN_RESET`, 64'h01ECC07802400000: reset value of `phase_inc_carrGen`.

Ports:
- `osc_clk` in 1: sole clock. The block has one clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `i_Rx_DV` in 1: one-cycle strobe, received byte valid.
- `i_Rx_Byte` in 8: received byte.
- `i_Tx_Active` in 1: UART transmitter busy.
- `o_Tx_DV` out 1: one-cycle strobe, response byte valid.
- `o_Tx_Byte` out 8: response byte.
- `phase_inc_carr` out 64: receive NCO phase increment.
- `phase_inc_carrGen` out 64: generator NCO phase increment.
- `o_load` out 2: one-cycle pulse; bit0 means carr updated, bit1 means gen updated.
- `o_frame_err` out 1: one-cycle pulse on checksum error, unknown command, or timeout.

## Operation
- Frame layout is 11 bytes:
  - SYNC = 0xA5.
  - CMD.
  - D7..D0, MSB first.
  - CSUM = XOR of CMD and D7..D0.
- CMD 0x01 targets `phase_inc_carr`. CMD 0x02 targets `phase_inc_carrGen`. Any other CMD is invalid.
- FSM states:
  - IDLE: on a byte equal to 0xA5, go to CMD. Any other byte is ignored silently.
  - CMD: latch CMD into the running checksum, clear byte index, go to DATA. Validity is checked only at CSUM.
  - DATA: shift the byte into a 64-bit shadow register (`shadow = {shadow[55:0], byte}`) and XOR it into the checksum. Increment the index; after the 8th byte (index 7) go to CSUM.
  - CSUM: on the byte:
    - If it matches the checksum and CMD is valid, copy shadow to the target output, pulse the matching `o_load` bit, and set response = 0x06 (ACK).
    - Otherwise, leave the outputs unchanged, pulse `o_frame_err`, and set response = 0x15 (NAK).
    - Go to RESP in both cases.
  - RESP: when `i_Tx_Active` is 0, drive `o_Tx_DV`=1 with `o_Tx_Byte`=response for exactly one cycle, then go to IDLE.
- Received bytes arriving while in RESP are dropped; they are not parsed.
- Shadow register and checksum are cleared on entry to CMD. A partially received frame never alters the outputs.
- Timeout:
  - An idle counter clears on every `i_Rx_DV` and runs only in CMD, DATA and CSUM.
  - When it reaches `TIMEOUT_CLKS`-1, the FSM goes to IDLE, pulses `o_frame_err`, and sends no response.
  - If `i_Rx_DV` arrives in the same cycle as the timeout, the byte wins: it is processed and the counter clears.

## Timing
- All outputs are registered.
- Values on `rst`:
  - `phase_inc_carr` = `CARR_RESET`, `phase_inc_carrGen` = `GEN_RESET`.
  - `o_Tx_DV`=0, `o_Tx_Byte`=0x00, `o_load`=0, `o_frame_err`=0.
  - FSM = IDLE, counters and shadow register = 0.
- `rst` asserted mid-frame aborts the frame without a response. Output registers return to their reset values.
- CSUM byte strobe at cycle N:
  - Output register update, `o_load`, and `o_frame_err` are visible at N+1.
  - FSM is in RESP at N+1.
  - `o_Tx_DV` asserts at N+2 if `i_Tx_Active`=0 at N+1; otherwise it asserts in the first cycle after `i_Tx_Active` is sampled 0.
- `o_Tx_DV` is never asserted for two consecutive cycles. At most one response is issued per frame.
- Back-to-back `i_Rx_DV` strobes on consecutive cycles are accepted; no minimum byte spacing is required.
- Throughput: one frame per 11 received bytes plus the response handshake.

## Test plan
- Reset check: assert `rst` for 2 cycles.
  - Outputs equal `CARR_RESET`/`GEN_RESET`; `o_Tx_DV`=0, `o_load`=0.
- Valid carrier write: send A5 01 00 00 00 00 12 34 56 78, then CSUM 0x01^0x12^0x34^0x56^0x78.
  - `phase_inc_carr`=64'h0000000012345678 one cycle after CSUM; `o_load`=2'b01 for one cycle.
  - ACK 0x06 is sent; `phase_inc_carrGen` is unchanged.
- Bad checksum: send a CMD 0x02 frame with CSUM xor 0x01.
  - `o_frame_err` pulses and NAK 0x15 is sent.
  - `phase_inc_carrGen` keeps its prior value; `o_load`=0.
- Unknown command and noise:
  - Bytes 00 FF 5A before SYNC are ignored.
  - A CMD 0x07 frame with a correct CSUM returns NAK 0x15; no output changes.
- Timeout: send A5 01 and 3 data bytes, then idle for `TIMEOUT_CLKS` (test value 50).
  - `o_frame_err` pulses once, with no `o_Tx_DV`.
  - A following complete valid frame is accepted and ACKed.
- Transmitter busy: hold `i_Tx_Active`=1 across CSUM for 20 cycles.
  - `o_Tx_DV` stays 0 until the cycle after `i_Tx_Active` falls, then pulses exactly once with 0x06.
  - Bytes sent during the wait are dropped.
